// File: rtl/smpldbit_vote_reg_pkg.sv
// can_smpl_pkg: shared encodings for the CAN sampled-bit path.
//   ctrl_t          bittime FSM command to the sampled-bit register
//   CTRL_*          command encodings
//   RECESSIVE/DOMINANT  bus level constants
package can_smpl_pkg;

  typedef logic [1:0] ctrl_t;

  localparam ctrl_t CTRL_HOLD      = 2'b00;
  localparam ctrl_t CTRL_RECESSIVE = 2'b01;
  localparam ctrl_t CTRL_COMMIT    = 2'b10;
  localparam ctrl_t CTRL_CLEAR     = 2'b11;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

endpackage

// File: rtl/smpldbit_vote_reg_majority_vote.sv
// majority_vote: combinational majority over N sample bits.
//   in_bits  N samples
//   vote     1 when more than N/2 of the samples are 1
module majority_vote #(
  parameter int N = 3
) (
  input  logic [N-1:0] in_bits,
  output logic         vote
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + CW'(in_bits[i]);
    end
    vote = (ones > CW'(N / 2));
  end

endmodule

// File: rtl/smpldbit_vote_reg.sv
// smpldbit_vote_reg: sampled-bit register for the CAN bit-timing path.
// Collects up to NSAMPLES puffer samples per bit time and commits one bit per
// bit time under bittime-FSM control (majority vote or latest sample).
//   clock, reset    clock and synchronous active-high reset
//   ctrl            00 hold, 01 force recessive, 10 commit, 11 clear samples
//   sample_en       capture puffer as a sample this cycle
//   puffer          edge puffer bus value
//   sam_mode        1 = majority over NSAMPLES, 0 = latest sample
//   smpldbit        committed bit (1 = recessive)
//   smpldbit_valid  one-cycle pulse when smpldbit takes a new committed value
//   bit_history     committed bits, [0] newest
//   stuck_dom       dominant run reached DOM_LIMIT
module smpldbit_vote_reg
  import can_smpl_pkg::*;
#(
  parameter int NSAMPLES   = 3,
  parameter int HIST_DEPTH = 4,
  parameter int DOM_LIMIT  = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            ctrl,
  input  logic                  sample_en,
  input  logic                  puffer,
  input  logic                  sam_mode,
  output logic                  smpldbit,
  output logic                  smpldbit_valid,
  output logic [HIST_DEPTH-1:0] bit_history,
  output logic                  stuck_dom
);

  localparam int CNT_W = $clog2(NSAMPLES + 1);
  localparam int RUN_W = $clog2(DOM_LIMIT + 1);

  if ((NSAMPLES % 2) == 0 || NSAMPLES < 1 || NSAMPLES > 5) begin : g_bad_nsamples
    $error("smpldbit_vote_reg: NSAMPLES must be odd and in 1..5");
  end
  if (HIST_DEPTH < 1 || HIST_DEPTH > 16) begin : g_bad_hist
    $error("smpldbit_vote_reg: HIST_DEPTH must be in 1..16");
  end
  if (DOM_LIMIT < 1 || DOM_LIMIT > 255) begin : g_bad_dom
    $error("smpldbit_vote_reg: DOM_LIMIT must be in 1..255");
  end

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(NSAMPLES)) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
    return (r == RUN_W'(DOM_LIMIT)) ? r : r + RUN_W'(1);
  endfunction

  logic [NSAMPLES-1:0]   smp_p1;
  logic [CNT_W-1:0]      cnt_p1;
  logic                  bit_p1;
  logic                  vld_p1;
  logic [HIST_DEPTH-1:0] hist_p1;
  logic [RUN_W-1:0]      run_p1;
  logic                  stuck_p1;

  logic [NSAMPLES-1:0]   eff_smp_p0;
  logic [CNT_W-1:0]      eff_cnt_p0;
  logic                  maj_p0;
  logic                  result_p0;

  logic [NSAMPLES-1:0]   smp_n;
  logic [CNT_W-1:0]      cnt_n;
  logic                  bit_n;
  logic                  vld_n;
  logic [HIST_DEPTH-1:0] hist_n;
  logic [RUN_W-1:0]      run_n;

  // ---- p0: effective samples (includes a same-cycle capture) and commit result
  always_comb begin
    eff_smp_p0 = sample_en ? NSAMPLES'({smp_p1, puffer}) : smp_p1;
    eff_cnt_p0 = sample_en ? cnt_sat_inc(cnt_p1) : cnt_p1;
  end

  majority_vote #(.N(NSAMPLES)) u_vote (
    .in_bits (eff_smp_p0),
    .vote    (maj_p0)
  );

  always_comb begin
    if (eff_cnt_p0 == '0)
      result_p0 = puffer;  // nothing sampled this bit: legacy delayed path
    else if (sam_mode && eff_cnt_p0 == CNT_W'(NSAMPLES))
      result_p0 = maj_p0;
    else
      result_p0 = eff_smp_p0[0];
  end

  always_comb begin
    smp_n  = eff_smp_p0;
    cnt_n  = eff_cnt_p0;
    bit_n  = bit_p1;
    vld_n  = 1'b0;
    hist_n = hist_p1;
    run_n  = run_p1;
    case (ctrl)
      CTRL_HOLD: ;
      CTRL_RECESSIVE: begin
        bit_n  = RECESSIVE;
        vld_n  = 1'b1;
        hist_n = HIST_DEPTH'({hist_p1, RECESSIVE});
        run_n  = '0;
        cnt_n  = '0;
      end
      CTRL_COMMIT: begin
        bit_n  = result_p0;
        vld_n  = 1'b1;
        hist_n = HIST_DEPTH'({hist_p1, result_p0});
        run_n  = (result_p0 == DOMINANT) ? run_sat_inc(run_p1) : '0;
        cnt_n  = '0;
      end
      CTRL_CLEAR: begin
        // a sample captured alongside a clear is discarded
        smp_n = '1;
        cnt_n = '0;
      end
      default: ;
    endcase
  end

  // ---- p1: registered state and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      smp_p1   <= '1;
      cnt_p1   <= '0;
      bit_p1   <= RECESSIVE;
      vld_p1   <= 1'b0;
      hist_p1  <= '1;
      run_p1   <= '0;
      stuck_p1 <= 1'b0;
    end else begin
      smp_p1   <= smp_n;
      cnt_p1   <= cnt_n;
      bit_p1   <= bit_n;
      vld_p1   <= vld_n;
      hist_p1  <= hist_n;
      run_p1   <= run_n;
      stuck_p1 <= (run_n == RUN_W'(DOM_LIMIT));
    end
  end

  assign smpldbit       = bit_p1;
  assign smpldbit_valid = vld_p1;
  assign bit_history    = hist_p1;
  assign stuck_dom      = stuck_p1;

endmodule

// File: tb/tb_smpldbit_vote_reg.sv
module tb_smpldbit_vote_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] ctrl;
  logic       sample_en;
  logic       puffer;
  logic       sam_mode;
  logic       smpldbit;
  logic       smpldbit_valid;
  logic [3:0] bit_history;
  logic       stuck_dom;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  smpldbit_vote_reg #(.NSAMPLES(3), .HIST_DEPTH(4), .DOM_LIMIT(11)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl           (ctrl),
    .sample_en      (sample_en),
    .puffer         (puffer),
    .sam_mode       (sam_mode),
    .smpldbit       (smpldbit),
    .smpldbit_valid (smpldbit_valid),
    .bit_history    (bit_history),
    .stuck_dom      (stuck_dom)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic samp(input logic v);
    ctrl = 2'b00; sample_en = 1'b1; puffer = v;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic commit(input logic puf, input logic sam, input logic se);
    ctrl = 2'b10; puffer = puf; sam_mode = sam; sample_en = se;
    tick();
    ctrl = 2'b00; sample_en = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic b, input logic v,
                         input logic [3:0] h, input logic s);
    chk({tag, "_bit"},   32'(smpldbit),       32'(b));
    chk({tag, "_vld"},   32'(smpldbit_valid), 32'(v));
    chk({tag, "_hist"},  32'(bit_history),    32'(h));
    chk({tag, "_stuck"}, 32'(stuck_dom),      32'(s));
  endtask

  initial begin
    reset = 1'b1; ctrl = 2'b00; sample_en = 1'b0; puffer = 1'b1; sam_mode = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // reset mid-collection with a commit pending
    samp(1'b0); samp(1'b0);
    reset = 1'b1; ctrl = 2'b10; puffer = 1'b0;
    tick();
    reset = 1'b0; ctrl = 2'b00;
    chk_out("rst", 1'b1, 1'b0, 4'b1111, 1'b0);

    // majority 0,1,0 -> 0, then hold
    samp(1'b0); samp(1'b1); samp(1'b0);
    commit(1'b1, 1'b1, 1'b0);
    chk_out("maj010", 1'b0, 1'b1, 4'b1110, 1'b0);
    tick();
    chk_out("hold", 1'b0, 1'b0, 4'b1110, 1'b0);

    // majority 1,0,1 -> 1
    samp(1'b1); samp(1'b0); samp(1'b1);
    commit(1'b0, 1'b1, 1'b0);
    chk_out("maj101", 1'b1, 1'b1, 4'b1101, 1'b0);

    // majority 1,1,0 -> 1 (newest would be 0)
    samp(1'b1); samp(1'b1); samp(1'b0);
    commit(1'b0, 1'b1, 1'b0);
    chk_out("maj110", 1'b1, 1'b1, 4'b1011, 1'b0);

    // single mode 1,1,0 -> newest 0
    samp(1'b1); samp(1'b1); samp(1'b0);
    commit(1'b1, 1'b0, 1'b0);
    chk_out("single110", 1'b0, 1'b1, 4'b0110, 1'b0);

    // no samples: legacy puffer path
    commit(1'b0, 1'b1, 1'b0);
    chk_out("legacy0", 1'b0, 1'b1, 4'b1100, 1'b0);
    commit(1'b1, 1'b1, 1'b0);
    chk_out("legacy1", 1'b1, 1'b1, 4'b1001, 1'b0);

    // four samples 0,1,1,0: count saturates at 3, buffer 1,1,0 -> majority 1
    samp(1'b0); samp(1'b1); samp(1'b1); samp(1'b0);
    commit(1'b0, 1'b1, 1'b0);
    chk_out("satcnt", 1'b1, 1'b1, 4'b0011, 1'b0);

    // same-cycle sample included: 0,0 + new 1, single mode -> 1
    samp(1'b0); samp(1'b0);
    commit(1'b1, 1'b0, 1'b1);
    chk_out("samecyc1", 1'b1, 1'b1, 4'b0111, 1'b0);

    // same-cycle sample, majority: 1,0 + new 0 -> 0
    samp(1'b1); samp(1'b0);
    commit(1'b0, 1'b1, 1'b1);
    chk_out("samecyc0", 1'b0, 1'b1, 4'b1110, 1'b0);

    // clear with sample_en: sample lost, bit held
    ctrl = 2'b11; sample_en = 1'b1; puffer = 1'b0;
    tick();
    ctrl = 2'b00; sample_en = 1'b0;
    chk_out("clear", 1'b0, 1'b0, 4'b1110, 1'b0);
    commit(1'b1, 1'b0, 1'b0);
    chk_out("afterclr", 1'b1, 1'b1, 4'b1101, 1'b0);

    // dominant run: 10 commits -> not stuck, 11th -> stuck, 12th stays stuck
    for (int i = 0; i < 10; i++) commit(1'b0, 1'b1, 1'b0);
    chk_out("dom10", 1'b0, 1'b1, 4'b0000, 1'b0);
    commit(1'b0, 1'b1, 1'b0);
    chk_out("dom11", 1'b0, 1'b1, 4'b0000, 1'b1);
    commit(1'b0, 1'b1, 1'b0);
    chk_out("dom12", 1'b0, 1'b1, 4'b0000, 1'b1);
    commit(1'b1, 1'b1, 1'b0);
    chk_out("domrec", 1'b1, 1'b1, 4'b0001, 1'b0);

    // build up again then force recessive
    for (int i = 0; i < 11; i++) commit(1'b0, 1'b1, 1'b0);
    chk_out("dom11b", 1'b0, 1'b1, 4'b0000, 1'b1);
    tick();
    chk_out("domhold", 1'b0, 1'b0, 4'b0000, 1'b1);
    ctrl = 2'b01;
    tick();
    ctrl = 2'b00;
    chk_out("forcerec", 1'b1, 1'b1, 4'b0001, 1'b0);
    commit(1'b0, 1'b1, 1'b0);
    chk_out("runclr", 1'b0, 1'b1, 4'b0010, 1'b0);

    // history of commits 0,1,1,0,1 -> [3:0] = 1,1,0,1
    commit(1'b0, 1'b1, 1'b0);
    commit(1'b1, 1'b1, 1'b0);
    commit(1'b1, 1'b1, 1'b0);
    commit(1'b0, 1'b1, 1'b0);
    commit(1'b1, 1'b1, 1'b0);
    chk_out("hist5", 1'b1, 1'b1, 4'b1101, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
